qam16_rx_demod: RTL and testbench
=================================

Name: qam16_rx_demod

Overview:
Receive-side counterpart of the TX chain (bit_gen -> qam16_mapper -> rrc_filter). It sits after the channel, or after the RX matched filter.
- Decimates the sample stream by SPS at a selectable sampling phase.
- Hard-slices I/Q into Gray-coded 4-bit QAM16 symbols.
- Compares each symbol against TX reference bits buffered in an internal FIFO, and accumulates symbol-error and bit-error statistics.
- Drives LEDs/HDMI overlay in later phases.

Parameters:
DATA_W, 12, width of signed I/Q samples (sample_t)
SPS, 4, samples per symbol (power of two, >=2)
THRESH, 512, slicer inner/outer decision threshold magnitude (mapper levels ±256/±768)
REF_DEPTH, 16, reference-bit FIFO depth (power of two)
CNT_W, 32, statistics counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rx_I  in  DATA_W  signed received I sample
rx_Q  in  DATA_W  signed received Q sample
rx_valid  in  1  sample qualifier
sample_phase  in  log2(SPS)  decimation phase select
ref_bits  in  4  TX reference symbol bits
ref_valid  in  1  push ref_bits into FIFO
ref_ready  out  1  FIFO not full
cmp_en  in  1  enable error accounting
clear_stats  in  1  synchronous clear of counters/flags
sym_out  out  4  sliced symbol {I[1:0],Q[1:0]}
sym_valid  out  1  one-cycle pulse per sliced symbol
sym_count  out  CNT_W  compared symbols
sym_err_count  out  CNT_W  symbols with >=1 bit error
bit_err_count  out  CNT_W  total bit errors
ref_overflow  out  1  sticky: push while full
ref_underflow  out  1  sticky: compare with FIFO empty

Behaviour:
Reset:
- rst asserted: all outputs 0, phase counter 0, FIFO empty. ref_ready reads 1 one cycle after rst deasserts.
- rst mid-operation discards FIFO contents and any in-flight symbol.

Decimation:
- phase_cnt increments on every rx_valid and wraps SPS-1 -> 0.
- Sample event = rx_valid && (phase_cnt == sample_phase).
- sample_phase is compared live; a change takes effect on the next rx_valid. phase_cnt is not reset by a phase change.

Slicer (applied per axis, signed compare):
- x < -THRESH -> 00
- -THRESH <= x < 0 -> 01
- 0 <= x < THRESH -> 11
- x >= THRESH -> 10
- Boundary values: x = -THRESH -> 01; x = 0 -> 11; x = THRESH -> 10.
- sym_out = {slice(I), slice(Q)}, registered. sym_valid pulses the cycle after the sample event (latency 1).
- sym_out holds its value between pulses.

Reference FIFO:
- Push when ref_valid && ref_ready. ref_valid while full: data dropped, ref_overflow set.
- Simultaneous push and pop when full: both occur, occupancy unchanged, no overflow.
- Push when empty is not visible to a same-cycle pop (no bypass).

Compare stage:
- Runs on the cycle sym_valid is high.
- FIFO non-empty: pop one entry.
- If cmp_en=1 after popping:
  - sym_count += 1
  - e = popcount(sym_out ^ ref)
  - bit_err_count += e
  - sym_err_count += (e != 0)
- If cmp_en=0 the entry is popped and discarded, which preserves alignment during filter warm-up.
- FIFO empty: no pop, no counting, ref_underflow set.
- Counter updates are visible the cycle after the sym_valid pulse.

Counters and flags:
- Counters saturate at all-ones and never wrap.
- clear_stats zeroes counters and sticky flags. It has priority over a same-cycle increment or flag set.
- clear_stats does not affect the FIFO, phase_cnt or sym_out.

Test Plan:
- Reset then idle: all outputs 0, ref_ready=1 after reset release.
- Decimation: feed SPS=4, sample_phase=2, rx_valid continuous, I=800, Q=-800 -> sym_valid every 4th cycle, sym_out=4'b1000.
- Slicer boundaries: I sequence -513, -512, -1, 0, 511, 512 on sample events -> I bits 00, 01, 01, 11, 11, 10.
- Error counting: push refs 4'b1000, 4'b0000; receive symbols 1000, 1111 with cmp_en=1 -> sym_count=2, sym_err_count=1, bit_err_count=4.
- FIFO boundaries:
  - 17 consecutive pushes with no pops -> ref_ready=0 after the 16th push; ref_overflow=1.
  - A symbol with the FIFO empty -> ref_underflow=1, counters unchanged.
  - Push and pop in the same cycle while full -> occupancy stays 16, no overflow.
- clear_stats asserted on the same cycle as an erroring compare -> all counters 0, flags 0. A reset mid-stream -> FIFO empty, outputs 0.

Source files
------------

// File: rtl/qam16_rx_demod.sv
// QAM16 receive demodulator: decimates I/Q by SPS, hard-slices to Gray-coded symbols and
// compares them against buffered TX reference bits to accumulate error statistics.
module qam16_rx_demod #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned SPS       = 4,
    parameter int unsigned THRESH    = 512,
    parameter int unsigned REF_DEPTH = 16,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_W-1:0]      rx_I,
    input  logic signed [DATA_W-1:0]      rx_Q,
    input  logic                          rx_valid,
    input  logic [$clog2(SPS)-1:0]        sample_phase,
    input  logic [3:0]                    ref_bits,
    input  logic                          ref_valid,
    output logic                          ref_ready,
    input  logic                          cmp_en,
    input  logic                          clear_stats,
    output logic [3:0]                    sym_out,
    output logic                          sym_valid,
    output logic [CNT_W-1:0]              sym_count,
    output logic [CNT_W-1:0]              sym_err_count,
    output logic [CNT_W-1:0]              bit_err_count,
    output logic                          ref_overflow,
    output logic                          ref_underflow
);

    localparam int unsigned PhW = $clog2(SPS);
    localparam int unsigned AW  = $clog2(REF_DEPTH);
    localparam int          ThreshI = int'(THRESH);

    function automatic logic [1:0] slice(input logic signed [DATA_W-1:0] x);
        int xi;
        xi = int'(x);
        if (xi < -ThreshI)     return 2'b00;
        else if (xi < 0)       return 2'b01;
        else if (xi < ThreshI) return 2'b11;
        else                   return 2'b10;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W - 2){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Decimation and slicer
    logic [PhW-1:0] phase_cnt_q;
    logic [3:0]     sym_out_q;
    logic           sym_valid_q;
    logic           sample_evt;

    assign sample_evt = rx_valid && (phase_cnt_q == sample_phase);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt_q <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
        end else begin
            if (rx_valid) phase_cnt_q <= phase_cnt_q + 1'b1;
            sym_valid_q <= sample_evt;
            if (sample_evt) sym_out_q <= {slice(rx_I), slice(rx_Q)};
        end
    end

    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;

    // Reference FIFO; extra pointer bit distinguishes full from empty
    logic [3:0]  mem_q [REF_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        ready_q;
    logic        full, empty, push, pop;
    logic [3:0]  ref_head;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop      = sym_valid_q && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a concurrent push
    assign push     = ref_valid && ready_q && (!full || pop);
    assign ref_head = mem_q[rd_ptr_q[AW-1:0]];
    assign ref_ready = ready_q && !full;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= ref_bits;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Compare stage and statistics
    logic [3:0]       diff;
    logic [2:0]       err_bits;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0] sym_err_q, sym_err_d;
    logic [CNT_W-1:0] bit_err_q, bit_err_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;

    assign diff     = sym_out_q ^ ref_head;
    assign err_bits = {2'b00, diff[0]} + {2'b00, diff[1]} + {2'b00, diff[2]} + {2'b00, diff[3]};

    always_comb begin
        sym_cnt_d = sym_cnt_q;
        sym_err_d = sym_err_q;
        bit_err_d = bit_err_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        if (clear_stats) begin
            sym_cnt_d = '0;
            sym_err_d = '0;
            bit_err_d = '0;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
        end else begin
            if (ref_valid && ready_q && full && !pop) ovf_d = 1'b1;
            if (sym_valid_q && empty) unf_d = 1'b1;
            if (pop && cmp_en) begin
                sym_cnt_d = sat_add(sym_cnt_q, 3'd1);
                bit_err_d = sat_add(bit_err_q, err_bits);
                sym_err_d = sat_add(sym_err_q, {2'b00, (err_bits != 3'd0)});
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_cnt_q <= '0;
            sym_err_q <= '0;
            bit_err_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            sym_err_q <= sym_err_d;
            bit_err_q <= bit_err_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign sym_count     = sym_cnt_q;
    assign sym_err_count = sym_err_q;
    assign bit_err_count = bit_err_q;
    assign ref_overflow  = ovf_q;
    assign ref_underflow = unf_q;

endmodule

// File: tb/tb_qam16_rx_demod.sv
// Directed self-checking bench for qam16_rx_demod (SPS=4, THRESH=512, 16-deep reference FIFO).
module tb_qam16_rx_demod;

    logic               clk;
    logic               rst;
    logic signed [11:0] rx_I, rx_Q;
    logic               rx_valid;
    logic [1:0]         sample_phase;
    logic [3:0]         ref_bits;
    logic               ref_valid, ref_ready;
    logic               cmp_en, clear_stats;
    logic [3:0]         sym_out;
    logic               sym_valid;
    logic [31:0]        sym_count, sym_err_count, bit_err_count;
    logic               ref_overflow, ref_underflow;

    int checks = 0;
    int failures = 0;

    qam16_rx_demod #(
        .DATA_W(12), .SPS(4), .THRESH(512), .REF_DEPTH(16), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .rx_I(rx_I), .rx_Q(rx_Q), .rx_valid(rx_valid),
        .sample_phase(sample_phase), .ref_bits(ref_bits), .ref_valid(ref_valid),
        .ref_ready(ref_ready), .cmp_en(cmp_en), .clear_stats(clear_stats),
        .sym_out(sym_out), .sym_valid(sym_valid), .sym_count(sym_count),
        .sym_err_count(sym_err_count), .bit_err_count(bit_err_count),
        .ref_overflow(ref_overflow), .ref_underflow(ref_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_ready);
        chk({tag, "_sym_valid"}, {31'd0, sym_valid}, 32'd0);
        chk({tag, "_sym_out"}, {28'd0, sym_out}, 32'd0);
        chk({tag, "_sym_count"}, sym_count, 32'd0);
        chk({tag, "_sym_err"}, sym_err_count, 32'd0);
        chk({tag, "_bit_err"}, bit_err_count, 32'd0);
        chk({tag, "_ovf"}, {31'd0, ref_overflow}, 32'd0);
        chk({tag, "_unf"}, {31'd0, ref_underflow}, 32'd0);
        chk({tag, "_ref_ready"}, {31'd0, ref_ready}, {31'd0, exp_ready});
    endtask

    // Holds one symbol for 4 valid samples starting at phase 0; the sample event is the
    // third, so the compare cycle is the fourth, where clr/push are applied.
    task automatic send_sym(input logic signed [11:0] i, input logic signed [11:0] q,
                            input logic clr, input logic push, input logic [3:0] rb);
        for (int k = 0; k < 4; k++) begin
            rx_I = i;
            rx_Q = q;
            rx_valid = 1'b1;
            if (k == 3) begin
                clear_stats = clr;
                ref_valid   = push;
                ref_bits    = rb;
            end
            step();
        end
        rx_valid    = 1'b0;
        clear_stats = 1'b0;
        ref_valid   = 1'b0;
    endtask

    task automatic push_ref(input logic [3:0] rb);
        ref_valid = 1'b1;
        ref_bits  = rb;
        step();
        ref_valid = 1'b0;
    endtask

    initial begin
        logic signed [11:0] bnd_val [6];
        logic [1:0]         bnd_exp [6];
        bnd_val = '{-12'sd513, -12'sd512, -12'sd1, 12'sd0, 12'sd511, 12'sd512};
        bnd_exp = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10};

        rst = 1'b1;
        rx_I = '0; rx_Q = '0; rx_valid = 1'b0; sample_phase = 2'd2;
        ref_bits = '0; ref_valid = 1'b0; cmp_en = 1'b0; clear_stats = 1'b0;
        step();
        step();
        chk_idle("in_reset", 1'b0);
        rst = 1'b0;
        step();
        chk_idle("post_reset", 1'b1);

        // Decimation: pulse after the 3rd and 7th valid edges
        rx_I = 12'sd800;
        rx_Q = -12'sd800;
        rx_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("decim_valid_%0d", k), {31'd0, sym_valid},
                (k == 3 || k == 7) ? 32'd1 : 32'd0);
            if (k == 3) chk("decim_sym", {28'd0, sym_out}, 32'h8);
        end
        rx_valid = 1'b0;
        chk("empty_unf", {31'd0, ref_underflow}, 32'd1);
        chk("empty_cnt", sym_count, 32'd0);
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        chk("clear_unf", {31'd0, ref_underflow}, 32'd0);

        // Slicer boundaries on I, Q=0 slices to 11
        for (int n = 0; n < 6; n++) begin
            send_sym(bnd_val[n], 12'sd0, 1'b0, 1'b0, 4'h0);
            chk($sformatf("slice_%0d", n), {28'd0, sym_out}, {28'd0, bnd_exp[n], 2'b11});
        end

        // Error counting
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        cmp_en = 1'b1;
        push_ref(4'b1000);
        push_ref(4'b0000);
        send_sym(12'sd800, -12'sd800, 1'b0, 1'b0, 4'h0);
        send_sym(12'sd300, 12'sd300, 1'b0, 1'b0, 4'h0);
        chk("err_sym_out", {28'd0, sym_out}, 32'hF);
        chk("err_sym_count", sym_count, 32'd2);
        chk("err_sym_err", sym_err_count, 32'd1);
        chk("err_bit_err", bit_err_count, 32'd4);
        chk("err_unf", {31'd0, ref_underflow}, 32'd0);

        // Fill FIFO with 0..15, then one more push overflows
        for (int n = 0; n < 16; n++) begin
            ref_valid = 1'b1;
            ref_bits  = 4'(n);
            step();
        end
        chk("full_ready", {31'd0, ref_ready}, 32'd0);
        chk("full_no_ovf", {31'd0, ref_overflow}, 32'd0);
        ref_bits = 4'hF;
        step();
        ref_valid = 1'b0;
        chk("full_ovf", {31'd0, ref_overflow}, 32'd1);
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        chk("clear_ovf", {31'd0, ref_overflow}, 32'd0);

        // Push and pop while full: pops entry 0 against symbol 1000
        send_sym(12'sd800, -12'sd800, 1'b0, 1'b1, 4'hA);
        chk("pp_ready", {31'd0, ref_ready}, 32'd0);
        chk("pp_ovf", {31'd0, ref_overflow}, 32'd0);
        chk("pp_sym_count", sym_count, 32'd1);
        chk("pp_sym_err", sym_err_count, 32'd1);
        chk("pp_bit_err", bit_err_count, 32'd1);

        // Clear on an erroring compare (1111 vs entry 1)
        send_sym(12'sd300, 12'sd300, 1'b1, 1'b0, 4'h0);
        chk("clr_sym_count", sym_count, 32'd0);
        chk("clr_sym_err", sym_err_count, 32'd0);
        chk("clr_bit_err", bit_err_count, 32'd0);
        chk("clr_ovf", {31'd0, ref_overflow}, 32'd0);
        chk("clr_unf", {31'd0, ref_underflow}, 32'd0);
        chk("clr_ready", {31'd0, ref_ready}, 32'd1);

        // Next entry is 2: 1000 ^ 0010 -> 2 bit errors
        send_sym(12'sd800, -12'sd800, 1'b0, 1'b0, 4'h0);
        chk("ord_sym_count", sym_count, 32'd1);
        chk("ord_bit_err", bit_err_count, 32'd2);

        // Reset mid-stream
        rx_valid = 1'b1;
        ref_valid = 1'b1;
        ref_bits = 4'h5;
        step();
        step();
        rst = 1'b1;
        #1;
        chk_idle("mid_reset", 1'b0);
        rx_valid = 1'b0;
        ref_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk_idle("mid_release", 1'b1);
        send_sym(12'sd800, -12'sd800, 1'b0, 1'b0, 4'h0);
        chk("rst_fifo_empty_unf", {31'd0, ref_underflow}, 32'd1);
        chk("rst_fifo_cnt", sym_count, 32'd0);
        chk("rst_sym_out", {28'd0, sym_out}, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
